// File: rtl/if_id_pipe_stage.sv
// IF/ID pipeline boundary: valid/ready handshake on both sides, 2-entry skid buffer,
// synchronous flush and NOP presentation whenever decode has no valid entry.
module if_id_pipe_stage #(
  parameter int unsigned       PC_W     = 32,
  parameter int unsigned       INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h00000013)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t              state;
  logic [PC_W-1:0]     skid_pc;
  logic [INST_W-1:0]   skid_inst;

  logic in_fire;
  logic out_fire;

  // Handshakes only see registered flags, so neither ready nor valid has a
  // combinational path from the opposite side of the stage.
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // out_pc/out_inst double as the main register; they are forced to 0/NOP
  // whenever the stage drops to EMPTY so decode never sees stale data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_inst  <= NOP_INST;
      skid_pc   <= '0;
      skid_inst <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_inst  <= NOP_INST;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state     <= FULL;
            out_valid <= 1'b1;
            out_pc    <= in_pc;
            out_inst  <= in_inst;
          end
        end
        FULL: begin
          if (in_fire && out_fire) begin
            out_pc   <= in_pc;
            out_inst <= in_inst;
          end else if (in_fire) begin
            // Decode stalled: park the new entry and stop accepting.
            state     <= SKID;
            in_ready  <= 1'b0;
            skid_pc   <= in_pc;
            skid_inst <= in_inst;
          end else if (out_fire) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_inst  <= NOP_INST;
          end
        end
        SKID: begin
          if (out_fire) begin
            state    <= FULL;
            in_ready <= 1'b1;
            out_pc   <= skid_pc;
            out_inst <= skid_inst;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_pc    <= '0;
          out_inst  <= NOP_INST;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_pipe_stage.sv
// Bench for if_id_pipe_stage: directed vector table, then random traffic against a queue model.
module tb_if_id_pipe_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_inst, out_pc, out_inst;

  int checks = 0;
  int errors = 0;

  if_id_pipe_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, flush, iv;
    logic [31:0] pc, inst;
    logic        ordy;
    logic        ev;
    logic [31:0] epc, einst;
    logic        eir;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic f, logic iv, logic [31:0] pc, logic [31:0] inst,
                              logic ordy, logic ev, logic [31:0] epc, logic [31:0] einst,
                              logic eir);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.pc = pc; v.inst = inst; v.ordy = ordy;
    v.ev = ev; v.epc = epc; v.einst = einst; v.eir = eir;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Drive one vector before the edge, check the post-edge outputs 1ns later.
  task automatic apply(vec_t v, int idx);
    @(negedge clk);
    rst = v.rst; flush = v.flush; in_valid = v.iv; in_pc = v.pc; in_inst = v.inst;
    out_ready = v.ordy;
    @(posedge clk);
    #1;
    chk("out_valid", idx, 32'(out_valid), 32'(v.ev));
    chk("out_pc",    idx, out_pc, v.epc);
    chk("out_inst",  idx, out_inst, v.einst);
    chk("in_ready",  idx, 32'(in_ready), 32'(v.eir));
  endtask

  typedef struct { logic [31:0] pc, inst; } ent_t;
  ent_t model[$];

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0;

    // Reset with in_valid held high: nothing may be accepted.
    vq.push_back(mk(1,0,1,32'h100,32'hFF,0, 0,0,NOP,1));
    vq.push_back(mk(1,0,1,32'h100,32'hFF,0, 0,0,NOP,1));
    // Streaming at full rate.
    vq.push_back(mk(0,0,1,32'h0,32'hA0,1, 1,32'h0,32'hA0,1));
    vq.push_back(mk(0,0,1,32'h4,32'hA1,1, 1,32'h4,32'hA1,1));
    vq.push_back(mk(0,0,1,32'h8,32'hA2,1, 1,32'h8,32'hA2,1));
    vq.push_back(mk(0,0,1,32'hC,32'hA3,1, 1,32'hC,32'hA3,1));
    vq.push_back(mk(0,0,0,32'h0,32'h0,1,  0,0,NOP,1));
    // Backpressure into the skid slot, hold for 5 cycles, then drain.
    vq.push_back(mk(0,0,1,32'h10,32'hB0,0, 1,32'h10,32'hB0,1));
    vq.push_back(mk(0,0,1,32'h14,32'hB1,0, 1,32'h10,32'hB0,0));
    for (int i = 0; i < 5; i++) vq.push_back(mk(0,0,0,32'h0,32'h0,0, 1,32'h10,32'hB0,0));
    vq.push_back(mk(0,0,0,32'h0,32'h0,1, 1,32'h14,32'hB1,1));
    vq.push_back(mk(0,0,0,32'h0,32'h0,1, 0,0,NOP,1));
    // Flush from SKID with a concurrent push; that push is dropped.
    vq.push_back(mk(0,0,1,32'h20,32'hC0,0, 1,32'h20,32'hC0,1));
    vq.push_back(mk(0,0,1,32'h24,32'hC1,0, 1,32'h20,32'hC0,0));
    vq.push_back(mk(0,1,1,32'h40,32'hC4,0, 0,0,NOP,1));
    vq.push_back(mk(0,0,1,32'h80,32'hC8,0, 1,32'h80,32'hC8,1));
    vq.push_back(mk(0,0,0,32'h0,32'h0,1,  0,0,NOP,1));
    // Simultaneous in_fire and out_fire in FULL: no bubble.
    vq.push_back(mk(0,0,1,32'h30,32'hD0,0, 1,32'h30,32'hD0,1));
    vq.push_back(mk(0,0,1,32'h34,32'hD1,1, 1,32'h34,32'hD1,1));
    vq.push_back(mk(0,0,0,32'h0,32'h0,1,  0,0,NOP,1));
    // Reset while two entries are held.
    vq.push_back(mk(0,0,1,32'h50,32'hE0,0, 1,32'h50,32'hE0,1));
    vq.push_back(mk(0,0,1,32'h54,32'hE1,0, 1,32'h50,32'hE0,0));
    vq.push_back(mk(1,0,0,32'h0,32'h0,0,  0,0,NOP,1));

    foreach (vq[i]) apply(vq[i], i);

    // Hand sequence: in_valid held while full; the blocked entry is taken only once ready returns.
    apply(mk(0,0,1,32'h60,32'hF0,0, 1,32'h60,32'hF0,1), 100);
    apply(mk(0,0,1,32'h64,32'hF1,0, 1,32'h60,32'hF0,0), 101);
    for (int i = 0; i < 3; i++) apply(mk(0,0,1,32'h68,32'hF2,0, 1,32'h60,32'hF0,0), 102 + i);
    apply(mk(0,0,1,32'h68,32'hF2,1, 1,32'h64,32'hF1,1), 105);
    apply(mk(0,0,1,32'h68,32'hF2,1, 1,32'h68,32'hF2,1), 106);
    apply(mk(0,0,0,32'h0,32'h0,1,   0,0,NOP,1), 107);
    // Flush together with an out_fire from FULL.
    apply(mk(0,0,1,32'h70,32'h70,0, 1,32'h70,32'h70,1), 108);
    apply(mk(0,1,0,32'h0,32'h0,1,   0,0,NOP,1), 109);

    // Random traffic against a FIFO model; stage is EMPTY here.
    model.delete();
    begin
      logic [31:0] next_pc = 32'h1000;
      for (int c = 0; c < 10000; c++) begin
        logic m_ready, m_valid, r_rst, r_fl, r_iv, r_or;
        @(negedge clk);
        m_valid = (model.size() != 0);
        m_ready = (model.size() < 2);
        chk("rnd_out_valid", c, 32'(out_valid), 32'(m_valid));
        chk("rnd_in_ready",  c, 32'(in_ready), 32'(m_ready));
        chk("rnd_out_pc",    c, out_pc,   m_valid ? model[0].pc   : 32'h0);
        chk("rnd_out_inst",  c, out_inst, m_valid ? model[0].inst : NOP);
        r_rst = ($urandom_range(999) < 3);
        r_fl  = ($urandom_range(99) < 2);
        r_iv  = ($urandom_range(99) < 65);
        r_or  = ($urandom_range(99) < 55);
        rst = r_rst; flush = r_fl; in_valid = r_iv; out_ready = r_or;
        in_pc = next_pc; in_inst = $urandom;
        if (r_rst || r_fl) begin
          model.delete();
        end else begin
          if (m_valid && r_or) void'(model.pop_front());
          if (r_iv && m_ready) model.push_back('{in_pc, in_inst});
        end
        if (r_iv) next_pc += 32'd4;
      end
      @(negedge clk);
      chk("rnd_final_valid", 10000, 32'(out_valid), 32'(model.size() != 0));
      chk("rnd_final_ready", 10000, 32'(in_ready), 32'(model.size() < 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
